// File: rtl/config_scan_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : config_scan_loader_if
//  Purpose  : Host-side word handshake and readback bus of the scan loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface config_scan_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [WORD_WIDTH-1:0] rb_word;
  logic                  rb_valid;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  rb_word,
    input  rb_valid
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output rb_word,
    output rb_valid
  );
endinterface
`default_nettype wire

// File: rtl/config_scan_loader.sv
`default_nettype none
// ============================================================================
//  Module   : config_scan_loader
//  Purpose  : Serialises host words LSB-first onto a configuration scan chain
//             and assembles the returning bits into readback words.
//  Revision : 1.0 - initial release
// ============================================================================
module config_scan_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  wire                  scan_clk,
  input  wire                  rst_n,
  input  wire                  start,
  input  wire                  abort,
  config_scan_loader_if.slave  host,
  output logic                 scan_data,
  output logic                 scan_en,
  input  wire                  scan_return,
  output logic                 busy,
  output logic                 done
);

  localparam int                   WB_W         = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] C_CHAIN_LAST = CNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [WB_W-1:0]      C_WORD_LAST  = WB_W'(WORD_WIDTH - 1);
  localparam logic [WB_W-1:0]      C_WORD_W     = WB_W'(WORD_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [CNT_WIDTH-1:0]  r_bit_cnt;
  logic [WB_W-1:0]       r_word_bit_cnt;
  logic [WORD_WIDTH-1:0] r_sreg;
  logic [WORD_WIDTH-1:0] r_rb_sreg;
  logic [WORD_WIDTH-1:0] r_rb_word;
  logic                  r_rb_valid;

  logic                  w_data_ready;
  logic                  w_scan_en;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_start_ok;
  logic                  w_accept;
  logic                  w_shift;
  logic                  w_chain_end;
  logic                  w_word_end;
  logic [WB_W-1:0]       w_align;
  logic [WORD_WIDTH-1:0] w_rb_shifted;
  logic [WORD_WIDTH-1:0] w_rb_aligned;

  assign w_chain_end = (r_bit_cnt == C_CHAIN_LAST);
  assign w_word_end  = (r_word_bit_cnt == C_WORD_LAST);
  assign w_start_ok  = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept    = (r_state == S_LOAD) && host.data_valid && !abort;
  assign w_shift     = (r_state == S_SHIFT) && !abort;

  // Returning bits enter at the MSB; a short final word is slid down so its
  // first bit lands in bit 0 and the unused upper bits read as zero.
  assign w_rb_shifted = {scan_return, r_rb_sreg[WORD_WIDTH-1:1]};
  assign w_align      = C_WORD_W - r_word_bit_cnt - WB_W'(1);
  assign w_rb_aligned = w_rb_shifted >> w_align;

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_data_ready = 1'b0;
    w_scan_en    = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_data_ready = 1'b1;
        w_busy       = 1'b1;
        if (host.data_valid) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_scan_en = 1'b1;
        w_busy    = 1'b1;
        if (w_chain_end) begin
          w_state_next = S_DONE;
        end else if (w_word_end) begin
          w_state_next = S_LOAD;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt      <= '0;
      r_word_bit_cnt <= '0;
      r_sreg         <= '0;
      r_rb_sreg      <= '0;
      r_rb_word      <= '0;
      r_rb_valid     <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_start_ok) begin
        r_bit_cnt      <= '0;
        r_word_bit_cnt <= '0;
      end
      if (w_accept) begin
        r_sreg         <= host.data_in;
        r_word_bit_cnt <= '0;
        r_rb_sreg      <= '0;
      end
      if (w_shift) begin
        r_sreg         <= r_sreg >> 1;
        r_bit_cnt      <= r_bit_cnt + CNT_WIDTH'(1);
        r_word_bit_cnt <= r_word_bit_cnt + WB_W'(1);
        r_rb_sreg      <= w_rb_shifted;
        if (w_chain_end || w_word_end) begin
          r_rb_word  <= w_rb_aligned;
          r_rb_valid <= 1'b1;
        end
      end
    end
  end

  assign scan_en         = w_scan_en;
  assign scan_data       = w_scan_en & r_sreg[0];
  assign busy            = w_busy;
  assign done            = w_done;
  assign host.data_ready = w_data_ready;
  assign host.rb_word    = r_rb_word;
  assign host.rb_valid   = r_rb_valid;

endmodule
`default_nettype wire
